// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg: shared opcode, tag and instruction-field definitions for the Tomasulo adder path
package tomasulo_pkg;
  localparam int TAG_W = 3;
  localparam logic [TAG_W-1:0] NO_TAG = '0;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001
  } op_e;
  localparam int OP_LSB   = 13;
  localparam int DEST_LSB = 10;
  localparam int SRCJ_LSB = 7;
  localparam int SRCK_LSB = 4;
  localparam int REG_W    = 3;
endpackage

// File: rtl/cdb_result_fifo.sv
// cdb_result_fifo: in-order result buffer; push and pop may coincide at any occupancy, including full
module cdb_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 22
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_pop, do_push;
  always_comb begin
    do_pop  = pop && cnt_q != '0;
    do_push = push && (cnt_q != (AW+1)'(DEPTH) || do_pop);
    mem_d   = mem_q;
    if (do_push) mem_d[wr_q] = push_data;
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
    mem_q <= mem_d;
  end
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign head  = empty ? '0 : mem_q[rd_q];
endmodule

// File: rtl/adder_exec_unit.sv
// adder_exec_unit: fixed-latency ADD/SUB pipeline feeding a CDB result buffer.
// Define ADDER_EXEC_SAT_EN for signed saturation instead of modulo wrap.
module adder_exec_unit
  import tomasulo_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [15:0]       InInst,
  input  logic [TAG_W-1:0]  InTag,
  input  logic [DATA_W-1:0] InVj,
  input  logic [DATA_W-1:0] InVk,
  output logic              CdbReq,
  input  logic              CdbGrant,
  output logic              CdbValid,
  output logic [TAG_W-1:0]  CdbTag,
  output logic [REG_W-1:0]  CdbDest,
  output logic [DATA_W-1:0] CdbData,
  output logic              Done
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = $clog2(LATENCY + DEPTH + 1);
  localparam int EW = TAG_W + REG_W + DATA_W;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [TAG_W-1:0]   tag_q  [LATENCY];
  logic [TAG_W-1:0]   tag_d  [LATENCY];
  logic [REG_W-1:0]   dest_q [LATENCY];
  logic [REG_W-1:0]   dest_d [LATENCY];
  logic [DATA_W-1:0]  res_q  [LATENCY];
  logic [DATA_W-1:0]  res_d  [LATENCY];
  logic               done_q, done_d;
  logic [2:0]         op;
  logic [DATA_W:0]    sum;
  logic [DATA_W-1:0]  arith, res_in;
  logic               accept, fifo_empty;
  logic [CW-1:0]      fifo_cnt;
  logic [FW-1:0]      inflight;
  logic [EW-1:0]      head;
  logic               unused_inst;
  assign op          = InInst[OP_LSB +: 3];
  assign unused_inst = ^{InInst[SRCJ_LSB +: 2*REG_W], InInst[SRCK_LSB-1:0]};
  // One extra sign bit makes overflow visible as a disagreement of the top two bits.
  always_comb begin
    sum = (op == OP_SUB) ? {InVj[DATA_W-1], InVj} - {InVk[DATA_W-1], InVk}
                         : {InVj[DATA_W-1], InVj} + {InVk[DATA_W-1], InVk};
    res_in = (op == OP_ADD || op == OP_SUB) ? arith : '0;
  end
`ifdef ADDER_EXEC_SAT_EN
  assign arith = (sum[DATA_W] != sum[DATA_W-1])
               ? {sum[DATA_W], {(DATA_W-1){~sum[DATA_W]}}} : sum[DATA_W-1:0];
`else
  logic unused_ovf;
  assign unused_ovf = sum[DATA_W];
  assign arith      = sum[DATA_W-1:0];
`endif
  assign accept = InValid && InReady && InTag != NO_TAG;
  always_comb begin
    vld_d[0]  = accept;
    tag_d[0]  = InTag;
    dest_d[0] = InInst[DEST_LSB +: REG_W];
    res_d[0]  = res_in;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      tag_d[i]  = tag_q[i-1];
      dest_d[i] = dest_q[i-1];
      res_d[i]  = res_q[i-1];
    end
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + FW'(vld_q[i]);
    done_d = CdbValid;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      vld_q  <= '0;
      done_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      done_q <= done_d;
    end
    tag_q  <= tag_d;
    dest_q <= dest_d;
    res_q  <= res_d;
  end
  cdb_result_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk       (Clock),
    .rst       (Reset),
    .push      (vld_q[LATENCY-1]),
    .push_data ({tag_q[LATENCY-1], dest_q[LATENCY-1], res_q[LATENCY-1]}),
    .pop       (CdbValid),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );
  assign InReady = !Reset && (inflight + FW'(fifo_cnt)) < FW'(DEPTH);
  assign CdbReq  = !Reset && !fifo_empty;
  assign CdbValid = CdbReq && CdbGrant;
  assign {CdbTag, CdbDest, CdbData} = head;
  assign Done = done_q;
endmodule

// File: tb/tb_adder_exec_unit.sv
// tb_adder_exec_unit: directed vectors with hand-computed results for adder_exec_unit (LATENCY=2, DEPTH=4)
module tb_adder_exec_unit;
  logic        Clock = 1'b0;
  logic        Reset, InValid, InReady, CdbReq, CdbGrant, CdbValid, Done;
  logic [15:0] InInst, InVj, InVk, CdbData;
  logic [2:0]  InTag, CdbTag, CdbDest;
  int tests = 0;
  int fails = 0;

  adder_exec_unit #(.LATENCY(2), .DEPTH(4), .DATA_W(16)) dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InInst(InInst), .InTag(InTag), .InVj(InVj), .InVk(InVk),
    .CdbReq(CdbReq), .CdbGrant(CdbGrant), .CdbValid(CdbValid), .CdbTag(CdbTag),
    .CdbDest(CdbDest), .CdbData(CdbData), .Done(Done)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #2;
  endtask

  task automatic drive(input logic [2:0] op, input logic [2:0] dest, input logic [2:0] tag,
                       input logic [15:0] vj, input logic [15:0] vk);
    InValid = 1'b1;
    InInst  = {op, dest, 3'd1, 3'd2, 4'd0};
    InTag   = tag;
    InVj    = vj;
    InVk    = vk;
  endtask

  task automatic send(input logic [2:0] op, input logic [2:0] dest, input logic [2:0] tag,
                      input logic [15:0] vj, input logic [15:0] vk);
    drive(op, dest, tag, vj, vk);
    step();
    InValid = 1'b0;
    #1;
  endtask

  task automatic wait_cdb(input string name, input logic [2:0] tag, input logic [15:0] data);
    int n = 0;
    while (!CdbValid && n < 20) begin
      step();
      n++;
    end
    chk({name, "_seen"}, CdbValid, 1);
    chk({name, "_tag"}, CdbTag, tag);
    chk({name, "_data"}, CdbData, data);
    step();
  endtask

  initial begin
    int acc;
    int seen;
    Reset = 1; InValid = 1; InTag = 3'd1; InInst = '0; InVj = 16'd1; InVk = 16'd1; CdbGrant = 0;
    step();
    step();
    #1;
    chk("rst_ready", InReady, 0);
    chk("rst_req", CdbReq, 0);
    chk("rst_done", Done, 0);
    chk("rst_valid", CdbValid, 0);
    chk("rst_data", CdbData, 0);
    Reset = 0; InValid = 0;
    step();
    chk("post_rst_ready", InReady, 1);
    step();
    step();
    chk("post_rst_nothing", CdbReq, 0);

    CdbGrant = 1;
    send(3'b000, 3'd3, 3'd1, 16'h0005, 16'h0003);
    chk("add_lat0", CdbValid, 0);
    step();
    chk("add_lat1", CdbValid, 0);
    step();
    chk("add_valid", CdbValid, 1);
    chk("add_tag", CdbTag, 1);
    chk("add_dest", CdbDest, 3);
    chk("add_data", CdbData, 16'h0008);
    chk("add_done_early", Done, 0);
    step();
    chk("add_done", Done, 1);
    chk("add_req_clear", CdbReq, 0);
    step();
    chk("add_done_pulse", Done, 0);

    send(3'b001, 3'd2, 3'd2, 16'h0000, 16'h0001);
    wait_cdb("sub_neg", 3'd2, 16'hFFFF);
`ifdef ADDER_EXEC_SAT_EN
    send(3'b000, 3'd1, 3'd3, 16'h7FFF, 16'h0001);
    wait_cdb("add_ovf", 3'd3, 16'h7FFF);
    send(3'b001, 3'd1, 3'd4, 16'h8000, 16'h0001);
    wait_cdb("sub_ovf", 3'd4, 16'h8000);
`else
    send(3'b000, 3'd1, 3'd3, 16'h7FFF, 16'h0001);
    wait_cdb("add_ovf", 3'd3, 16'h8000);
    send(3'b001, 3'd1, 3'd4, 16'h8000, 16'h0001);
    wait_cdb("sub_ovf", 3'd4, 16'h7FFF);
`endif

    send(3'b000, 3'd1, 3'd0, 16'h0005, 16'h0003);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      seen += int'(CdbReq);
      step();
    end
    chk("tag0_ignored", seen, 0);
    send(3'b111, 3'd6, 3'd5, 16'h0005, 16'h0003);
    wait_cdb("illegal_op", 3'd5, 16'h0000);

    CdbGrant = 0;
    acc = 0;
    for (int t = 1; t <= 7; t++) begin
      drive(3'b000, 3'd0, 3'(t), 16'(t), 16'h0010);
      acc += int'(InReady);
      step();
    end
    InValid = 0;
    #1;
    chk("bp_accepts", acc, 4);
    chk("bp_ready_low", InReady, 0);
    chk("bp_req", CdbReq, 1);
    chk("bp_no_valid", CdbValid, 0);
    CdbGrant = 1;
    #1;
    for (int k = 1; k <= 4; k++) begin
      chk("bp_valid", CdbValid, 1);
      chk("bp_tag", CdbTag, k);
      chk("bp_data", CdbData, 16'(k) + 16'h0010);
      if (k == 1) chk("bp_ready_before_pop", InReady, 0);
      if (k == 2) chk("bp_ready_after_pop", InReady, 1);
      step();
    end
    chk("bp_drained", CdbReq, 0);
    step();

    CdbGrant = 0;
    for (int t = 1; t <= 3; t++) begin
      drive(3'b000, 3'd0, 3'(t), 16'h0100, 16'(t));
      step();
    end
    InValid = 0;
    step();
    step();
    chk("mid_buffered", CdbReq, 1);
    Reset = 1;
    #1;
    chk("mid_rst_ready", InReady, 0);
    step();
    Reset = 0;
    CdbGrant = 1;
    #1;
    chk("mid_req_clear", CdbReq, 0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      seen += int'(CdbValid);
      step();
    end
    chk("mid_no_stale", seen, 0);
    send(3'b000, 3'd7, 3'd6, 16'h1234, 16'h1111);
    wait_cdb("post_mid", 3'd6, 16'h2345);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/adder_exec_unit.md
# adder_exec_unit

Execution-and-writeback end of the adder reservation-station protocol: accepts one dispatched ADD/SUB per cycle with operand values and a station tag, computes the result through a fixed-latency pipeline, buffers completed results and broadcasts each on the Common Data Bus (tag + value). Sits between the adder reservation station (dispatch side) and the CDB arbiter (broadcast side); waiting stations and the register-status table consume its broadcasts.

## Interface
Parameters:
- LATENCY, 2, execute pipeline stages from accept to result-buffer write (legal 1..8)
- DEPTH, 4, result buffer entries (legal 2..8, power of two)
- DATA_W, 16, operand/result width

Ports:
- Clock  in  1  single clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high
- InValid  in  1  dispatch request from reservation station
- InReady  out  1  unit can accept a dispatch this cycle
- InInst  in  16  instruction word; [15:13] opcode, [12:10] dest reg, [9:7] src j, [6:4] src k
- InTag  in  3  issuing station tag; 0 = no station (never valid)
- InVj  in  DATA_W  operand j value
- InVk  in  DATA_W  operand k value
- CdbReq  out  1  result buffer non-empty, requesting the bus
- CdbGrant  in  1  arbiter grant for this unit
- CdbValid  out  1  broadcast strobe this cycle
- CdbTag  out  3  tag of broadcast result
- CdbDest  out  3  destination register of broadcast result
- CdbData  out  DATA_W  broadcast result value
- Done  out  1  registered pulse, one cycle after each broadcast

## Operation
- Accept: InValid && InReady && InTag != 0 at a rising edge. InValid with InTag == 0 is ignored (no state change).
- InReady = !Reset && (in-flight count + buffer count) < DEPTH; guarantees the buffer never overflows.
- Opcode 000: ADD (Vj + Vk). 001: SUB (Vj - Vk). Any other opcode: result 0, still broadcast with its tag so the station frees.
- Arithmetic: DATA_W-bit two's complement, wrap-around on overflow (see Configuration).
- Pipeline: LATENCY-deep shift of {valid, tag, dest, result}; one new entry per cycle, fully pipelined, no stalls (space pre-reserved by InReady).
- Result buffer: FIFO, in-order; push from pipeline tail, pop on broadcast; simultaneous push and pop in the same cycle permitted at any occupancy, including full.
- Broadcast: CdbReq = buffer non-empty. CdbTag/CdbDest/CdbData always show buffer head (0 when empty). CdbValid = CdbReq && CdbGrant (combinational); head pops on that edge. CdbGrant while empty: no effect.
- Done: registered copy of CdbValid.

## Timing
- Reset values: InReady 0 during Reset, 1 the cycle after; CdbReq, CdbValid, Done 0; CdbTag, CdbDest, CdbData 0; pipeline and buffer emptied.
- Reset mid-operation discards all in-flight and buffered results; no broadcast of them after reset.
- Accept at edge N -> buffer write at edge N+LATENCY -> CdbReq high from that edge; with grant held, CdbValid in cycle after edge N+LATENCY, Done one cycle later.
- Back-to-back dispatches with constant grant: one broadcast per cycle, order identical to accept order.
- Grant withheld: buffer fills; InReady drops when in-flight + buffered == DEPTH, rises the cycle after a pop.

## Configuration
- ADDER_EXEC_SAT_EN defined: ADD/SUB saturate to signed max 0x7FFF / min 0x8000 (DATA_W=16) on overflow.
- Undefined: plain modulo-2^DATA_W wrap.

## Structure
- Shared package tomasulo_pkg: opcode constants (OP_ADD=3'b000, OP_SUB=3'b001), TAG_W=3, NO_TAG=0, instruction field bit positions; also used by the reservation station and register-status table.
- One sub-module: cdb_result_fifo (parameterised DEPTH x {tag, dest, data}, push/pop/count, same-cycle push+pop).

## Test plan
- Reset: hold Reset 2 cycles with InValid=1 -> InReady=0, CdbReq=0, Done=0; nothing accepted.
- Single ADD: tag 1, Vj=0x0005, Vk=0x0003, grant=1 -> CdbValid LATENCY+1 cycles after accept, CdbTag=1, CdbData=0x0008; Done next cycle.
- SUB wrap: Vj=0x0000, Vk=0x0001 -> CdbData=0xFFFF (with ADDER_EXEC_SAT_EN: 0x7FFF+1 case -> 0x7FFF).
- Backpressure: grant=0, issue tags 1..7 every cycle -> InReady falls after 4 accepts; release grant -> broadcasts tags 1,2,3,4 in order, one per cycle, InReady reasserts.
- Tag 0 / illegal opcode: InTag=0 -> no broadcast; opcode 111 tag 5 -> broadcast tag 5 data 0.
- Reset mid-flight: 3 results buffered, pulse Reset -> CdbReq=0, no stale broadcasts afterward.
